// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side FIFO signals between the controller (master), memory, write-side sync and consumer.
interface fifo_rd_ctrl_if #(parameter int ADDR_WIDTH = 4);
    logic [ADDR_WIDTH-1:0] wptr_gray_sync;
    logic [7:0]            rdata_mem;
    logic [ADDR_WIDTH-2:0] raddr;
    logic [ADDR_WIDTH-1:0] rptr_gray;
    logic                  rempty;
    logic [ADDR_WIDTH-1:0] rd_count;
    logic                  rd_valid;
    logic [7:0]            rd_data;
    logic                  rd_ready;
    logic                  rd_aempty;
    modport master(
        input  wptr_gray_sync, rdata_mem, rd_ready,
        output raddr, rptr_gray, rempty, rd_count, rd_valid, rd_data, rd_aempty
    );
    modport slave(
        output wptr_gray_sync, rdata_mem, rd_ready,
        input  raddr, rptr_gray, rempty, rd_count, rd_valid, rd_data, rd_aempty
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side pointers, empty/level status and one-word prefetch output register.
// Optional almost-empty flag enabled by defining FIFO_RD_AEMPTY_EN.
module fifo_rd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input logic            rclk,
    input logic            rrst_n,
    fifo_rd_ctrl_if.master bus
);
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH-1:0] r_rptr_gray;
    logic                  r_rd_valid;
    logic [7:0]            r_rd_data;
    logic [ADDR_WIDTH-1:0] w_wbin;
    logic [ADDR_WIDTH-1:0] w_rptr_nxt;
    logic                  w_rempty;
    logic                  w_fetch;
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) w_wbin[i] = ^(bus.wptr_gray_sync >> i);
    end
    assign w_rempty   = r_rptr_gray == bus.wptr_gray_sync;
    assign w_fetch    = !w_rempty && (!r_rd_valid || bus.rd_ready);
    assign w_rptr_nxt = r_rptr + ADDR_WIDTH'(w_fetch);
    // Gray pointer is registered so the write-domain synchroniser never sees decode glitches
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) begin
            r_rptr      <= '0;
            r_rptr_gray <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 8'h00;
        end else begin
            r_rptr      <= w_rptr_nxt;
            r_rptr_gray <= w_rptr_nxt ^ (w_rptr_nxt >> 1);
            r_rd_valid  <= w_fetch ? 1'b1 : (r_rd_valid && bus.rd_ready) ? 1'b0 : r_rd_valid;
            r_rd_data   <= w_fetch ? bus.rdata_mem : r_rd_data;
        end
    assign bus.raddr     = r_rptr[ADDR_WIDTH-2:0];
    assign bus.rptr_gray = r_rptr_gray;
    assign bus.rempty    = w_rempty;
    assign bus.rd_count  = w_wbin - r_rptr;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
`ifdef FIFO_RD_AEMPTY_EN
    logic [ADDR_WIDTH-1:0] w_count_nxt;
    logic                  r_rd_aempty;
    assign w_count_nxt = w_wbin - w_rptr_nxt;
    // post-fetch level keeps the flag aligned with the pointer update
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) r_rd_aempty <= 1'b1;
        else r_rd_aempty <= w_count_nxt <= ADDR_WIDTH'(AE_THRESH);
    assign bus.rd_aempty = r_rd_aempty;
`else
    assign bus.rd_aempty = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized bench with a queue-based FIFO model and an in-order data scoreboard.
module tb_fifo_rd_ctrl;
    localparam int AW = 4;
    localparam int DEPTH = 8;
    localparam int AE = 2;
    logic clk = 1'b0;
    logic rrst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] mem [DEPTH];
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [AW-1:0] wp = '0;
    logic [AW-1:0] rp = '0;
    logic       mv = 1'b0;
    logic [7:0] md = 8'h00;
    logic       eae = 1'b0;
    fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
    fifo_rd_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
        .rclk(clk), .rrst_n(rrst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    assign bus.rdata_mem = mem[bus.raddr];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic ae_reset();
`ifdef FIFO_RD_AEMPTY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic ae_after(input int lvl);
`ifdef FIFO_RD_AEMPTY_EN
        return lvl <= AE;
`else
        return lvl < 0;
`endif
    endfunction
    task automatic model_reset();
        q.delete();
        sent.delete();
        wp = '0;
        rp = '0;
        mv = 1'b0;
        md = 8'h00;
        eae = ae_reset();
        bus.wptr_gray_sync = '0;
    endtask
    task automatic chk_reset_state();
        chk("rst_valid", 32'(bus.rd_valid), 0);
        chk("rst_data", 32'(bus.rd_data), 0);
        chk("rst_gray", 32'(bus.rptr_gray), 0);
        chk("rst_empty", 32'(bus.rempty), 1);
        chk("rst_count", 32'(bus.rd_count), 0);
        chk("rst_aempty", 32'(bus.rd_aempty), 32'(ae_reset()));
    endtask
    // one cycle: optional writes and ready applied after a negedge, checks, then model advance
    task automatic step(input int nwr, input bit rdy);
        bit fetch;
        for (int k = 0; k < nwr; k++)
            if (q.size() < DEPTH) begin
                logic [7:0] d;
                d = 8'($urandom);
                mem[wp[AW-2:0]] = d;
                q.push_back(d);
                sent.push_back(d);
                wp = wp + 1'b1;
            end
        bus.wptr_gray_sync = wp ^ (wp >> 1);
        bus.rd_ready = rdy;
        #1;
        chk("rempty", 32'(bus.rempty), 32'(q.size() == 0));
        chk("rd_count", 32'(bus.rd_count), 32'(q.size()));
        chk("rd_valid", 32'(bus.rd_valid), 32'(mv));
        chk("rd_data", 32'(bus.rd_data), 32'(md));
        chk("rptr_gray", 32'(bus.rptr_gray), 32'(rp ^ (rp >> 1)));
        chk("raddr", 32'(bus.raddr), 32'(rp % DEPTH));
        chk("rd_aempty", 32'(bus.rd_aempty), 32'(eae));
        if (bus.rd_valid && rdy && sent.size() != 0) chk("order", 32'(bus.rd_data), 32'(sent.pop_front()));
        fetch = q.size() != 0 && (!mv || rdy);
        if (fetch) begin
            md = q.pop_front();
            mv = 1'b1;
            rp = rp + 1'b1;
        end else if (mv && rdy) mv = 1'b0;
        eae = ae_after(q.size());
        @(negedge clk);
    endtask
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        bus.wptr_gray_sync = '0;
        bus.rd_ready = 1'b0;
        #2 rrst_n = 1'b0;
        #1 chk_reset_state();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rrst_n = 1'b1;
        step(1, 1'b0);
        step(0, 1'b0);
        step(0, 1'b1);
        step(0, 1'b0);
        step(3, 1'b0);
        for (int i = 0; i < 10; i++) step(0, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        step(8, 1'b0);
        for (int i = 0; i < 20; i++) step(1, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 1'b1);
        for (int i = 0; i < 1500; i++) step(int'($urandom_range(0, 2)), ($urandom % 4) != 0);
        step(3, 1'b0);
        step(0, 1'b0);
        #2 rrst_n = 1'b0;
        #1 chk("mid_rst_valid", 32'(bus.rd_valid), 0);
        chk("mid_rst_gray", 32'(bus.rptr_gray), 0);
        chk("mid_rst_data", 32'(bus.rd_data), 0);
        model_reset();
        #1 chk_reset_state();
        @(negedge clk);
        rrst_n = 1'b1;
        for (int i = 0; i < 400; i++) step(int'($urandom_range(0, 3)), ($urandom % 3) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the async FIFO, running in the read clock domain. Owns the binary and Gray read pointers and generates the memory read address. Compares its read pointer against the write pointer, which arrives already synchronised into rclk, and produces empty status and fill level. Presents one registered output word through a valid/ready handshake: a prefetch stage that drains the dual-port memory whenever the output register is free.

Parameters:
FIFO_DEPTH  8  number of memory entries; must equal 2^(ADDR_WIDTH-1)
ADDR_WIDTH  4  pointer width; one extra MSB over the memory address for wrap detection
AE_THRESH   2  almost-empty threshold in entries; used only with FIFO_RD_AEMPTY_EN

Ports:
rclk            in   1             read-domain clock
rrst_n          in   1             asynchronous active-low reset
wptr_gray_sync  in   ADDR_WIDTH    write pointer, Gray-coded, already 2-flop synchronised to rclk
rdata_mem       in   8             memory read data; combinational from raddr
raddr           out  ADDR_WIDTH-1  memory read address
rptr_gray       out  ADDR_WIDTH    registered Gray read pointer, sent to the write-domain synchroniser
rempty          out  1             memory holds no unread entry
rd_count        out  ADDR_WIDTH    entries in memory not yet fetched, range 0..FIFO_DEPTH
rd_valid        out  1             rd_data holds a valid word
rd_data         out  8             output word
rd_ready        in   1             consumer accepts rd_data this cycle
rd_aempty       out  1             almost-empty flag (see Optional Feature)

Behaviour:
- One clock (rclk). Reset is asynchronous, active-low (rrst_n), and takes effect without a clock edge.
- Reset values: rptr (internal binary) = 0, rptr_gray = 0, rd_valid = 0, rd_data = 0x00.
- Reset values, derived from pointers: rempty = 1 and rd_count = 0 when wptr_gray_sync = 0.
- Reset value of rd_aempty: 1 with the macro, 0 without.
- raddr = rptr[ADDR_WIDTH-2:0].
- rempty = (rptr_gray == wptr_gray_sync); combinational.
- rptr_gray is a register loaded with next_rptr ^ (next_rptr >> 1) on the same edge as rptr. It is never a combinational decode, so it is glitch-free for the CDC.
- Write pointer conversion: wbin = Gray-to-binary(wptr_gray_sync), where each bit is the XOR of that bit and all higher bits.
- rd_count = (wbin - rptr) mod 2^ADDR_WIDTH. It excludes the word held in rd_data.
- Fetch condition: fetch = !rempty && (!rd_valid || rd_ready).
- On fetch, at the next rclk edge: rd_data <= rdata_mem, rd_valid <= 1, rptr <= rptr + 1.
- Otherwise, if rd_valid && rd_ready: rd_valid <= 0, and rd_data holds its value.
- Otherwise: rd_valid and rd_data hold.
- Throughput is one word per cycle with continuous rd_ready and non-empty memory.
- Latency: a word becomes visible on rd_valid/rd_data 1 rclk edge after rempty is seen low.
- Simultaneous pop and refill: rd_ready=1 with rd_valid=1 and !rempty replaces rd_data in the same cycle, with no bubble.
- rd_ready while rd_valid=0 is ignored.
- Wrap: rptr counts modulo 2^ADDR_WIDTH. raddr wraps FIFO_DEPTH-1 -> 0, and the pointer MSB toggles each lap.
- Full memory: rd_count = FIFO_DEPTH when the wbin and rptr MSBs differ and the remaining bits are equal.
- Stale wptr_gray_sync is conservative: the block only under-reports data, and never reads an unwritten entry.
- Underflow is impossible by construction, because there is no fetch while rempty=1.

Optional Feature:
FIFO_RD_AEMPTY_EN
- Defined: rd_aempty is a register updated each rclk with (next rd_count <= AE_THRESH). It uses the post-fetch count, so the flag is aligned with the pointer update. Reset value 1.
- Undefined: rd_aempty is tied to 0, AE_THRESH is unused, and no extra flops are inferred.
- The port exists in both builds.

Test Plan (ADDR_WIDTH=4, FIFO_DEPTH=8):
1. Reset: assert rrst_n=0 mid-clock with wptr_gray_sync=0000 -> immediately rd_valid=0, rd_data=0x00, rptr_gray=0000, rempty=1, rd_count=0.
2. Single word: mem[0]=0xA5, wptr_gray_sync 0000->0001 -> next edge rd_valid=1, rd_data=0xA5, rptr_gray=0001, rempty=1; then rd_ready=1 for one cycle -> rd_valid=0.
3. Backpressure: mem[0..2]=0x11,0x22,0x33, wptr_gray_sync=0010 (bin 3), rd_ready=0 -> rd_data holds 0x11, rd_count=2 for 10 cycles. Then rd_ready=1 -> 0x22, 0x33 on consecutive cycles, and rd_valid=0 after 0x33 is accepted.
4. Full and wrap: wptr_gray_sync=1100 (bin 8), rptr=0 -> rd_count=8, rempty=0. Drain 16 words over two laps with rd_ready=1 -> raddr runs 0..7,0..7; rptr_gray passes 0100->1100 at bin 7->8 and 1000->0000 at bin 15->0. Data matches mem order.
5. Reset mid-stream: rd_valid=1, rptr=5, pulse rrst_n=0 without a clock edge -> rd_valid=0 and rptr_gray=0000 immediately. Pointers restart at 0 after release.
6. With FIFO_RD_AEMPTY_EN, AE_THRESH=2: rd_count=4 -> rd_aempty=0. Fetch twice (rd_count reaches 2) -> rd_aempty=1 on the edge of the second fetch. Without the macro -> rd_aempty=0 throughout.
